// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin arbiter that shares the single write port of the 54-bit
//   instruction/result FIFO among NUM_REQ producers. It keeps its own credit
//   count of FIFO entries, so it never issues a write into a full FIFO and
//   never has to wait for the FIFO's lagging full flag.
//
//   Optional feature (macro FIFO_ARB_GRANT_CNT_EN): adds the grant_cnt output
//   port, which holds one 16-bit wrapping issue counter per requester.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   req, req_data       per-requester valid and flattened data words
//   gnt                 combinational one-hot grant (transfer on req & gnt)
//   pop                 copy of the FIFO read_enable (one entry leaves)
//   fifo_write_enable   registered FIFO write strobe
//   fifo_data_in        registered FIFO write data
//   occupancy           registered credit count, 0..FIFO_DEPTH
//   almost_full         occupancy >= AFULL_LVL
//   cred_full           occupancy == FIFO_DEPTH
//   underflow_err       sticky; pop arrived while occupancy was 0
//   grant_cnt           (optional) 16 bits per requester, issue counts
module fifo_write_arbiter #(
   parameter int WORD_SIZE  = 54,
   parameter int NUM_REQ    = 4,
   parameter int FIFO_DEPTH = 21,
   parameter int AFULL_LVL  = 18
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*WORD_SIZE-1:0] req_data,
   output logic [NUM_REQ-1:0]           gnt,
   input  logic                         pop,
   output logic                         fifo_write_enable,
   output logic [WORD_SIZE-1:0]         fifo_data_in,
   output logic [4:0]                   occupancy,
   output logic                         almost_full,
   output logic                         cred_full,
`ifdef FIFO_ARB_GRANT_CNT_EN
   output logic [16*NUM_REQ-1:0]        grant_cnt,
`endif
   output logic                         underflow_err
);

   localparam int         IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);
   localparam logic [4:0] AFULL_C = 5'(AFULL_LVL);
   localparam logic [IDX_W-1:0] LAST_C = IDX_W'(NUM_REQ - 1);

   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] winner;
   logic             found;
   logic             issue;
   logic             pop_ok;
   logic [4:0]       occ_next;

   // Search from rr_ptr upward with wrap; first active request wins.
   always_comb begin
      int idx;
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = IDX_W'(idx);
         end
      end
   end

   // Grant depends only on registered state and req, never on pop: a pop in
   // the full cycle frees a credit that becomes usable on the next cycle.
   always_comb begin
      gnt = '0;
      if (found && !cred_full && !reset)
         gnt[winner] = 1'b1;
   end

   assign issue  = |gnt;
   assign pop_ok = pop && (occupancy != 5'd0);

   always_comb begin
      occ_next = occupancy;
      if (issue && !pop_ok)
         occ_next = occupancy + 5'd1;
      else if (!issue && pop_ok)
         occ_next = occupancy - 5'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr            <= '0;
         fifo_write_enable <= 1'b0;
         fifo_data_in      <= '0;
         occupancy         <= '0;
         almost_full       <= 1'b0;
         cred_full         <= 1'b0;
         underflow_err     <= 1'b0;
      end else begin
         fifo_write_enable <= issue;
         if (issue) begin
            fifo_data_in <= req_data[winner*WORD_SIZE +: WORD_SIZE];
            rr_ptr       <= (winner == LAST_C) ? '0 : winner + IDX_W'(1);
         end
         occupancy   <= occ_next;
         // Flags come from the next-state count so they line up with occupancy.
         almost_full <= (occ_next >= AFULL_C);
         cred_full   <= (occ_next == DEPTH_C);
         if (pop && (occupancy == 5'd0))
            underflow_err <= 1'b1;
      end
   end

`ifdef FIFO_ARB_GRANT_CNT_EN
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
      logic [15:0] cnt;
      always_ff @(posedge clk) begin
         if (reset)
            cnt <= '0;
         else if (gnt[i])
            cnt <= cnt + 16'd1;   // wraps 65535 -> 0
      end
      assign grant_cnt[i*16 +: 16] = cnt;
   end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter. Inputs are driven on the
// falling edge; outputs are checked on the falling edge (or 1 time unit after
// driving, for the combinational grant). Expected write data is queued at
// grant time and compared when fifo_write_enable shows up.
module tb_fifo_write_arbiter;

   localparam int W = 54;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] req_data = '0;
   logic           pop = 1'b0;
   logic [N-1:0]   gnt;
   logic           fifo_write_enable;
   logic [W-1:0]   fifo_data_in;
   logic [4:0]     occupancy;
   logic           almost_full, cred_full, underflow_err;
`ifdef FIFO_ARB_GRANT_CNT_EN
   logic [16*N-1:0] grant_cnt;
`endif

   int           n_chk  = 0;
   int           n_fail = 0;
   logic [W-1:0] sb[$];
   int           gcnt[N];

   fifo_write_arbiter #(.WORD_SIZE(W), .NUM_REQ(N), .FIFO_DEPTH(21), .AFULL_LVL(18)) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt), .pop(pop),
      .fifo_write_enable(fifo_write_enable), .fifo_data_in(fifo_data_in),
      .occupancy(occupancy), .almost_full(almost_full), .cred_full(cred_full),
`ifdef FIFO_ARB_GRANT_CNT_EN
      .grant_cnt(grant_cnt),
`endif
      .underflow_err(underflow_err));

   always #5 clk = ~clk;

   // Scoreboard consumer: every FIFO write must match the oldest queued word.
   always @(negedge clk) begin
      if (fifo_write_enable === 1'b1) begin
         n_chk++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected_write: got %h, no write expected", fifo_data_in);
         end else begin
            logic [W-1:0] e;
            e = sb.pop_front();
            if (fifo_data_in !== e) begin
               n_fail++;
               $display("FAIL sb_data: got %h expected %h", fifo_data_in, e);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_word(input int i, input logic [W-1:0] v);
      req_data[i*W +: W] = v;
   endtask

   // Record an expected issue for requester i this cycle.
   task automatic expect_issue(input int i);
      sb.push_back(req_data[i*W +: W]);
      gcnt[i]++;
   endtask

   task automatic do_reset();
      reset = 1'b1; req = '0; pop = 1'b0;
      cyc(); cyc();
      for (int i = 0; i < N; i++) gcnt[i] = 0;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; req = 4'b1111; pop = 1'b0;
      @(negedge clk); #1;
      n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_gnt: got %b expected 0000", gnt); end
      cyc();
      n_chk++; if (fifo_write_enable !== 1'b0) begin n_fail++; $display("FAIL rst_fwe: got %b expected 0", fifo_write_enable); end
      n_chk++; if (fifo_data_in !== '0) begin n_fail++; $display("FAIL rst_data: got %h expected 0", fifo_data_in); end
      n_chk++; if (occupancy !== 5'd0) begin n_fail++; $display("FAIL rst_occ: got %0d expected 0", occupancy); end
      n_chk++; if ({almost_full, cred_full, underflow_err} !== 3'b000) begin
         n_fail++; $display("FAIL rst_flags: got %b expected 000", {almost_full, cred_full, underflow_err}); end
      do_reset();
   endtask

   task automatic test_rotate();
      do_reset();
      for (int i = 0; i < N; i++) set_word(i, W'(i + 1));
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         n_chk++; if (gnt !== 4'(1 << (k % N))) begin n_fail++; $display("FAIL rot_gnt[%0d]: got %b expected %b", k, gnt, 4'(1 << (k % N))); end
         n_chk++; if (fifo_write_enable !== (k != 0)) begin n_fail++; $display("FAIL rot_fwe[%0d]: got %b expected %b", k, fifo_write_enable, k != 0); end
         expect_issue(k % N);
         cyc();
      end
      req = '0;
      cyc();
      n_chk++; if (occupancy !== 5'd5) begin n_fail++; $display("FAIL rot_occ: got %0d expected 5", occupancy); end
   endtask

   task automatic test_fill_and_full_pop();
      do_reset();
      set_word(0, 54'h2A_5A5A_0001);
      req = 4'b0001;
      for (int k = 0; k < 21; k++) begin
         #1;
         n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL fill_gnt[%0d]: got %b expected 0001", k, gnt); end
         expect_issue(0);
         cyc();
         n_chk++; if (occupancy !== 5'(k + 1)) begin n_fail++; $display("FAIL fill_occ[%0d]: got %0d expected %0d", k, occupancy, k + 1); end
         n_chk++; if (almost_full !== (k + 1 >= 18)) begin n_fail++; $display("FAIL fill_afull[%0d]: got %b expected %b", k, almost_full, k + 1 >= 18); end
         n_chk++; if (cred_full !== (k + 1 == 21)) begin n_fail++; $display("FAIL fill_cfull[%0d]: got %b expected %b", k, cred_full, k + 1 == 21); end
      end
      #1;
      n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL full_gnt: got %b expected 0000", gnt); end
      // Pop at full: grant must still be low in this cycle.
      pop = 1'b1; #1;
      n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL full_pop_gnt: got %b expected 0000", gnt); end
      cyc();
      pop = 1'b0;
      n_chk++; if (occupancy !== 5'd20 || cred_full !== 1'b0) begin n_fail++; $display("FAIL full_pop_occ: got %0d/%b expected 20/0", occupancy, cred_full); end
      #1;
      n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL refill_gnt: got %b expected 0001", gnt); end
      expect_issue(0);
      cyc();
      n_chk++; if (occupancy !== 5'd21 || cred_full !== 1'b1) begin n_fail++; $display("FAIL refill_occ: got %0d/%b expected 21/1", occupancy, cred_full); end
      #1;
      n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL refill_gnt_low: got %b expected 0000", gnt); end
      req = '0;
   endtask

   task automatic test_issue_and_pop();
      do_reset();
      set_word(2, 54'h3_0000_BEEF);
      req = 4'b0100;
      for (int k = 0; k < 10; k++) begin
         expect_issue(2);
         cyc();
      end
      n_chk++; if (occupancy !== 5'd10) begin n_fail++; $display("FAIL sim_pre_occ: got %0d expected 10", occupancy); end
      pop = 1'b1; #1;
      n_chk++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL sim_gnt: got %b expected 0100", gnt); end
      expect_issue(2);
      cyc();
      pop = 1'b0; req = '0;
      n_chk++; if (occupancy !== 5'd10) begin n_fail++; $display("FAIL sim_occ: got %0d expected 10", occupancy); end
      n_chk++; if (fifo_write_enable !== 1'b1) begin n_fail++; $display("FAIL sim_fwe: got %b expected 1", fifo_write_enable); end
      cyc();
      n_chk++; if (fifo_write_enable !== 1'b0) begin n_fail++; $display("FAIL sim_fwe_idle: got %b expected 0", fifo_write_enable); end
      n_chk++; if (fifo_data_in !== 54'h3_0000_BEEF) begin n_fail++; $display("FAIL sim_data_hold: got %h expected 30000beef", fifo_data_in); end
   endtask

   task automatic test_underflow();
      do_reset();
      pop = 1'b1;
      cyc();
      pop = 1'b0;
      n_chk++; if (occupancy !== 5'd0) begin n_fail++; $display("FAIL uf_occ: got %0d expected 0", occupancy); end
      n_chk++; if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL uf_set: got %b expected 1", underflow_err); end
      cyc(); cyc(); cyc();
      n_chk++; if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %b expected 1", underflow_err); end
      do_reset();
      n_chk++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL uf_clear: got %b expected 0", underflow_err); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < N; i++) set_word(i, W'(32'hA0 + i));
      req = 4'b1010;
      #1;
      n_chk++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL mid_gnt0: got %b expected 0010", gnt); end
      expect_issue(1);
      cyc();
`ifdef FIFO_ARB_GRANT_CNT_EN
      for (int i = 0; i < N; i++) begin
         n_chk++; if (grant_cnt[i*16 +: 16] !== 16'(gcnt[i])) begin n_fail++; $display("FAIL gcnt[%0d]: got %0d expected %0d", i, grant_cnt[i*16 +: 16], gcnt[i]); end
      end
`endif
      // rr_ptr now points at 2; reset must bring it back to 0.
      reset = 1'b1; #1;
      n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_gnt: got %b expected 0000", gnt); end
      cyc();
      for (int i = 0; i < N; i++) gcnt[i] = 0;
      n_chk++; if (fifo_write_enable !== 1'b0 || occupancy !== 5'd0) begin
         n_fail++; $display("FAIL mid_rst_state: got fwe=%b occ=%0d expected fwe=0 occ=0", fifo_write_enable, occupancy); end
`ifdef FIFO_ARB_GRANT_CNT_EN
      n_chk++; if (grant_cnt !== '0) begin n_fail++; $display("FAIL gcnt_rst: got %h expected 0", grant_cnt); end
`endif
      reset = 1'b0; #1;
      n_chk++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL mid_first_gnt: got %b expected 0010", gnt); end
      expect_issue(1);
      cyc();
      #1;
      n_chk++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL mid_second_gnt: got %b expected 1000", gnt); end
      expect_issue(3);
      cyc();
      req = '0;
      cyc();
`ifdef FIFO_ARB_GRANT_CNT_EN
      for (int i = 0; i < N; i++) begin
         n_chk++; if (grant_cnt[i*16 +: 16] !== 16'(gcnt[i])) begin n_fail++; $display("FAIL gcnt_end[%0d]: got %0d expected %0d", i, grant_cnt[i*16 +: 16], gcnt[i]); end
      end
`endif
   endtask

   initial begin
      for (int i = 0; i < N; i++) gcnt[i] = 0;
      test_reset();
      test_rotate();
      test_fill_and_full_pop();
      test_issue_and_pop();
      test_underflow();
      test_reset_mid();
      cyc();
      n_chk++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: %0d writes outstanding, expected 0", sb.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
